// File: rtl/race_pkg.sv
// Shared definitions for the race game controller and its datapath:
// state codes, the default movement-tick period and the command decode.
package race_pkg;

  localparam int unsigned TICKS_PER_MOVE_DEFAULT = 833333;
  localparam int          TICK_WIDTH             = 20;
  localparam logic [15:0] RACE_TIME_MAX          = 16'hFFFF;

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_DRAW_BG   = 4'd1,
    S_WAIT_GO   = 4'd2,
    S_WAIT_REL  = 4'd3,
    S_START     = 4'd4,
    S_DRAW_CAR  = 4'd5,
    S_WAIT_TICK = 4'd6,
    S_ERASE     = 4'd7,
    S_MOVE      = 4'd8,
    S_EXPLODE   = 4'd9,
    S_OVER      = 4'd10
  } state_t;

  typedef struct packed {
    logic set_reset_signals;
    logic start_race;
    logic draw_background;
    logic draw_car;
    logic draw_over_car;
    logic move;
    logic draw_explosion;
  } cmd_t;

  // Each state drives at most one command, which keeps the commands one-hot.
  function automatic cmd_t decode_cmds(input state_t s);
    cmd_t c;
    c = '0;
    case (s)
      S_RESET:    c.set_reset_signals = 1'b1;
      S_DRAW_BG:  c.draw_background   = 1'b1;
      S_START:    c.start_race        = 1'b1;
      S_DRAW_CAR: c.draw_car          = 1'b1;
      S_ERASE:    c.draw_over_car     = 1'b1;
      S_MOVE:     c.move              = 1'b1;
      S_EXPLODE:  c.draw_explosion    = 1'b1;
      default:    c = '0;
    endcase
    return c;
  endfunction

  // States during which the race clock runs.
  function automatic logic in_race(input state_t s);
    return (s == S_DRAW_CAR) || (s == S_WAIT_TICK) ||
           (s == S_ERASE)    || (s == S_MOVE);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running movement-tick divider: counts 0..TICKS_PER_MOVE-1 and flags
// the last count of each period.
module tick_gen
  import race_pkg::*;
#(
  parameter int unsigned TICKS_PER_MOVE = TICKS_PER_MOVE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam logic [TICK_WIDTH-1:0] LAST = TICK_WIDTH'(TICKS_PER_MOVE - 1);

  logic [TICK_WIDTH-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/race_control.sv
// Moore controller for the race game: sequences background/car drawing,
// movement on ticks, crash and finish handling, and keeps the race time.
module race_control
  import race_pkg::*;
#(
  parameter int unsigned TICKS_PER_MOVE = TICKS_PER_MOVE_DEFAULT
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Go,
  input  logic        KeyActive,
  input  logic        DoneDrawBackground,
  input  logic        DoneDrawCar,
  input  logic        DoneDrawOverCar,
  input  logic        DoneDrawExplosion,
  input  logic        FinishedRace,
  input  logic        HitWall,
  output logic        set_reset_signals,
  output logic        start_race,
  output logic        draw_background,
  output logic        draw_car,
  output logic        draw_over_car,
  output logic        move,
  output logic        draw_explosion,
  output logic        plot,
  output logic        Crashed,
  output logic [15:0] raceTime,
  output logic [3:0]  stateOut
);

  state_t state;
  cmd_t   cmd;
  logic   tick;
  logic   go_prev;
  logic   draw_pending;

  tick_gen #(
    .TICKS_PER_MOVE(TICKS_PER_MOVE)
  ) u_tick_gen (
    .clk  (Clock),
    .reset(Reset),
    .tick (tick)
  );

  always_comb cmd = decode_cmds(state);

  // A draw state still emitting pixels; plot is this, registered, so it lines
  // up with the datapath's registered pixel coordinates and colour.
  // NOTE: give every always_comb output a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    draw_pending = 1'b0;
    case (state)
      S_DRAW_BG:  draw_pending = !DoneDrawBackground;
      S_DRAW_CAR: draw_pending = !DoneDrawCar;
      S_ERASE:    draw_pending = !DoneDrawOverCar;
      S_EXPLODE:  draw_pending = !DoneDrawExplosion;
      default:    draw_pending = 1'b0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= S_RESET;
      go_prev  <= 1'b0;
      plot     <= 1'b0;
      Crashed  <= 1'b0;
      raceTime <= '0;
    end else begin
      go_prev <= Go;
      plot    <= draw_pending;

      if (tick && in_race(state) && (raceTime != RACE_TIME_MAX)) begin
        raceTime <= raceTime + 16'd1;
      end

      case (state)
        S_RESET: begin
          state    <= S_DRAW_BG;
          raceTime <= '0;
          Crashed  <= 1'b0;
        end
        S_DRAW_BG:  if (DoneDrawBackground) state <= S_WAIT_GO;
        S_WAIT_GO:  if (Go) state <= S_WAIT_REL;
        S_WAIT_REL: if (!Go) state <= S_START;
        S_START:    state <= S_DRAW_CAR;
        S_DRAW_CAR: begin
          // A wall hit wins over a normal move when both arrive together.
          if (DoneDrawCar) begin
            if (HitWall) begin
              state   <= S_EXPLODE;
              Crashed <= 1'b1;
            end else begin
              state <= S_WAIT_TICK;
            end
          end
        end
        S_WAIT_TICK: begin
          if (tick) begin
            if (FinishedRace)   state <= S_OVER;
            else if (KeyActive) state <= S_ERASE;
          end
        end
        S_ERASE: if (DoneDrawOverCar) state <= S_MOVE;
        S_MOVE:  state <= S_DRAW_CAR;
        S_EXPLODE: begin
          Crashed <= 1'b1;
          if (DoneDrawExplosion) state <= S_OVER;
        end
        S_OVER: begin
          // Restart only on a fresh press, not on a key still held.
          if (Go && !go_prev) begin
            state   <= S_RESET;
            Crashed <= 1'b0;
          end
        end
        default: state <= S_RESET;
      endcase
    end
  end

  assign set_reset_signals = cmd.set_reset_signals;
  assign start_race        = cmd.start_race;
  assign draw_background   = cmd.draw_background;
  assign draw_car          = cmd.draw_car;
  assign draw_over_car     = cmd.draw_over_car;
  assign move              = cmd.move;
  assign draw_explosion    = cmd.draw_explosion;
  assign stateOut          = state;

endmodule

// File: tb/tb_race_control.sv
// Directed bench for race_control with a short movement period; the datapath
// completion flags are driven by hand from each scenario task.
module tb_race_control;

  localparam int unsigned TPM = 4;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Go = 1'b0;
  logic        KeyActive = 1'b0;
  logic        DoneDrawBackground = 1'b0;
  logic        DoneDrawCar = 1'b0;
  logic        DoneDrawOverCar = 1'b0;
  logic        DoneDrawExplosion = 1'b0;
  logic        FinishedRace = 1'b0;
  logic        HitWall = 1'b0;
  logic        set_reset_signals, start_race, draw_background, draw_car;
  logic        draw_over_car, move, draw_explosion, plot, Crashed;
  logic [15:0] raceTime;
  logic [3:0]  stateOut;

  int   total = 0;
  int   bad = 0;
  logic mon_en = 1'b0;
  logic plot_exp_next = 1'b0;
  int   tb_cnt = 0;

  race_control #(.TICKS_PER_MOVE(TPM)) dut (
    .Clock(Clock), .Reset(Reset), .Go(Go), .KeyActive(KeyActive),
    .DoneDrawBackground(DoneDrawBackground), .DoneDrawCar(DoneDrawCar),
    .DoneDrawOverCar(DoneDrawOverCar), .DoneDrawExplosion(DoneDrawExplosion),
    .FinishedRace(FinishedRace), .HitWall(HitWall),
    .set_reset_signals(set_reset_signals), .start_race(start_race),
    .draw_background(draw_background), .draw_car(draw_car),
    .draw_over_car(draw_over_car), .move(move), .draw_explosion(draw_explosion),
    .plot(plot), .Crashed(Crashed), .raceTime(raceTime), .stateOut(stateOut)
  );

  always #5 Clock = ~Clock;

  // Reference tick counter: value currently held by the design's divider.
  always @(posedge Clock) tb_cnt <= (Reset || tb_cnt == TPM - 1) ? 0 : tb_cnt + 1;

  // Continuous properties: plot lags the pending draw by one cycle, commands one-hot.
  always @(negedge Clock) begin
    if (mon_en) begin
      total++;
      if (plot !== plot_exp_next) begin
        bad++;
        $display("FAIL plot_track t=%0t: got %b want %b", $time, plot, plot_exp_next);
      end
      total++;
      if ($countones({set_reset_signals, start_race, draw_background, draw_car,
                      draw_over_car, move, draw_explosion}) > 1) begin
        bad++;
        $display("FAIL one_hot t=%0t: got state %0d with several commands", $time, stateOut);
      end
    end
    plot_exp_next = !Reset && ((draw_background && !DoneDrawBackground) ||
                               (draw_car && !DoneDrawCar) ||
                               (draw_over_car && !DoneDrawOverCar) ||
                               (draw_explosion && !DoneDrawExplosion));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // From S_DRAW_BG to S_WAIT_TICK along the normal start path.
  task automatic run_to_wait_tick();
    DoneDrawBackground = 1'b1; step(); DoneDrawBackground = 1'b0;
    Go = 1'b1; step();
    Go = 1'b0; step();
    step();
    DoneDrawCar = 1'b1; step(); DoneDrawCar = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    step(); step();
    Reset = 1'b0;
    total++;
    if (set_reset_signals !== 1'b1 || stateOut !== 4'd0) begin
      bad++;
      $display("FAIL reset_cycle1: got srs=%b state=%0d want srs=1 state=0", set_reset_signals, stateOut);
    end
    total++;
    if (raceTime !== 16'd0 || Crashed !== 1'b0 || plot !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: got time=%0d crashed=%b plot=%b want 0 0 0", raceTime, Crashed, plot);
    end
    mon_en = 1'b1;
    step();
    total++;
    if (draw_background !== 1'b1 || stateOut !== 4'd1) begin
      bad++;
      $display("FAIL reset_cycle2: got bg=%b state=%0d want bg=1 state=1", draw_background, stateOut);
    end
    step();
    total++;
    if (stateOut !== 4'd1 || plot !== 1'b1) begin
      bad++;
      $display("FAIL bg_wait: got state=%0d plot=%b want state=1 plot=1", stateOut, plot);
    end
    DoneDrawBackground = 1'b1; step(); DoneDrawBackground = 1'b0;
    total++;
    if (stateOut !== 4'd2 || plot !== 1'b0) begin
      bad++;
      $display("FAIL bg_done: got state=%0d plot=%b want state=2 plot=0", stateOut, plot);
    end
  endtask

  task automatic test_go_start();
    Go = 1'b1; step();
    total++;
    if (stateOut !== 4'd3) begin
      bad++;
      $display("FAIL go_press: got state=%0d want 3", stateOut);
    end
    step(); step();
    total++;
    if (stateOut !== 4'd3 || start_race !== 1'b0) begin
      bad++;
      $display("FAIL go_hold: got state=%0d start=%b want state=3 start=0", stateOut, start_race);
    end
    Go = 1'b0; step();
    total++;
    if (start_race !== 1'b1 || stateOut !== 4'd4) begin
      bad++;
      $display("FAIL start_pulse: got start=%b state=%0d want start=1 state=4", start_race, stateOut);
    end
    step();
    total++;
    if (start_race !== 1'b0 || draw_car !== 1'b1 || stateOut !== 4'd5) begin
      bad++;
      $display("FAIL start_to_car: got start=%b car=%b state=%0d want 0 1 5", start_race, draw_car, stateOut);
    end
  endtask

  task automatic test_move();
    logic [15:0] rt0;
    logic [3:0]  exp_state;
    logic        reached;
    step();
    total++;
    if (draw_car !== 1'b1 || plot !== 1'b1) begin
      bad++;
      $display("FAIL car_plot: got car=%b plot=%b want 1 1", draw_car, plot);
    end
    DoneDrawCar = 1'b1; step(); DoneDrawCar = 1'b0;
    total++;
    if (stateOut !== 4'd6 || draw_car !== 1'b0 || plot !== 1'b0) begin
      bad++;
      $display("FAIL car_done: got state=%0d car=%b plot=%b want 6 0 0", stateOut, draw_car, plot);
    end
    rt0 = raceTime;
    repeat (8) step();
    total++;
    if (stateOut !== 4'd6 || raceTime !== rt0 + 16'd2) begin
      bad++;
      $display("FAIL race_time_rate: got state=%0d time=%0d want 6 %0d", stateOut, raceTime, rt0 + 16'd2);
    end
    KeyActive = 1'b1;
    reached = 1'b0;
    for (int i = 0; i <= TPM && !reached; i++) begin
      exp_state = (tb_cnt == TPM - 1) ? 4'd7 : 4'd6;
      step();
      total++;
      if (stateOut !== exp_state) begin
        bad++;
        $display("FAIL key_tick: got state=%0d want %0d", stateOut, exp_state);
        reached = 1'b1;
      end else if (stateOut == 4'd7) begin
        reached = 1'b1;
      end
    end
    KeyActive = 1'b0;
    total++;
    if (draw_over_car !== 1'b1) begin
      bad++;
      $display("FAIL erase_cmd: got over_car=%b want 1", draw_over_car);
    end
    step();
    total++;
    if (stateOut !== 4'd7 || plot !== 1'b1) begin
      bad++;
      $display("FAIL erase_hold: got state=%0d plot=%b want 7 1", stateOut, plot);
    end
    DoneDrawOverCar = 1'b1; step(); DoneDrawOverCar = 1'b0;
    total++;
    if (move !== 1'b1 || stateOut !== 4'd8) begin
      bad++;
      $display("FAIL move_pulse: got move=%b state=%0d want 1 8", move, stateOut);
    end
    step();
    total++;
    if (move !== 1'b0 || draw_car !== 1'b1 || stateOut !== 4'd5) begin
      bad++;
      $display("FAIL move_to_car: got move=%b car=%b state=%0d want 0 1 5", move, draw_car, stateOut);
    end
  endtask

  task automatic test_crash();
    logic [15:0] rt0;
    DoneDrawCar = 1'b1; HitWall = 1'b1; KeyActive = 1'b1;
    step();
    DoneDrawCar = 1'b0; HitWall = 1'b0; KeyActive = 1'b0;
    total++;
    if (stateOut !== 4'd9 || draw_explosion !== 1'b1 || Crashed !== 1'b1) begin
      bad++;
      $display("FAIL hit_priority: got state=%0d expl=%b crashed=%b want 9 1 1", stateOut, draw_explosion, Crashed);
    end
    rt0 = raceTime;
    repeat (5) step();
    total++;
    if (stateOut !== 4'd9 || raceTime !== rt0) begin
      bad++;
      $display("FAIL explode_freeze: got state=%0d time=%0d want 9 %0d", stateOut, raceTime, rt0);
    end
    DoneDrawExplosion = 1'b1; step(); DoneDrawExplosion = 1'b0;
    total++;
    if (stateOut !== 4'd10 || Crashed !== 1'b1 || draw_explosion !== 1'b0) begin
      bad++;
      $display("FAIL over_entry: got state=%0d crashed=%b expl=%b want 10 1 0", stateOut, Crashed, draw_explosion);
    end
    repeat (5) step();
    total++;
    if (stateOut !== 4'd10 || raceTime !== rt0) begin
      bad++;
      $display("FAIL over_freeze: got state=%0d time=%0d want 10 %0d", stateOut, raceTime, rt0);
    end
    Go = 1'b1; step();
    total++;
    if (set_reset_signals !== 1'b1 || Crashed !== 1'b0 || stateOut !== 4'd0) begin
      bad++;
      $display("FAIL restart: got srs=%b crashed=%b state=%0d want 1 0 0", set_reset_signals, Crashed, stateOut);
    end
    Go = 1'b0; step();
    total++;
    if (stateOut !== 4'd1 || raceTime !== 16'd0) begin
      bad++;
      $display("FAIL restart_clear: got state=%0d time=%0d want 1 0", stateOut, raceTime);
    end
  endtask

  task automatic test_finish();
    logic [3:0] exp_state;
    logic       reached;
    run_to_wait_tick();
    total++;
    if (stateOut !== 4'd6) begin
      bad++;
      $display("FAIL finish_setup: got state=%0d want 6", stateOut);
    end
    for (int i = 0; i < TPM && tb_cnt != 0; i++) step();
    FinishedRace = 1'b1; KeyActive = 1'b1; Go = 1'b1;
    reached = 1'b0;
    for (int i = 0; i <= TPM && !reached; i++) begin
      exp_state = (tb_cnt == TPM - 1) ? 4'd10 : 4'd6;
      step();
      total++;
      if (stateOut !== exp_state) begin
        bad++;
        $display("FAIL finish_tick: got state=%0d want %0d", stateOut, exp_state);
        reached = 1'b1;
      end else if (stateOut == 4'd10) begin
        reached = 1'b1;
      end
    end
    total++;
    if (stateOut !== 4'd10 || Crashed !== 1'b0) begin
      bad++;
      $display("FAIL finish_over: got state=%0d crashed=%b want 10 0", stateOut, Crashed);
    end
    repeat (4) step();
    total++;
    if (stateOut !== 4'd10) begin
      bad++;
      $display("FAIL go_held: got state=%0d want 10", stateOut);
    end
    Go = 1'b0; step();
    total++;
    if (stateOut !== 4'd10) begin
      bad++;
      $display("FAIL go_low: got state=%0d want 10", stateOut);
    end
    FinishedRace = 1'b0; KeyActive = 1'b0;
    Go = 1'b1; step(); Go = 1'b0;
    total++;
    if (stateOut !== 4'd0 || set_reset_signals !== 1'b1) begin
      bad++;
      $display("FAIL go_edge: got state=%0d srs=%b want 0 1", stateOut, set_reset_signals);
    end
  endtask

  task automatic test_reset_mid_erase();
    step();
    run_to_wait_tick();
    KeyActive = 1'b1;
    for (int i = 0; i <= TPM && stateOut != 4'd7; i++) step();
    KeyActive = 1'b0;
    total++;
    if (stateOut !== 4'd7) begin
      bad++;
      $display("FAIL erase_reached: got state=%0d want 7", stateOut);
    end
    step();
    Reset = 1'b1; step(); Reset = 1'b0;
    total++;
    if (draw_over_car !== 1'b0 || set_reset_signals !== 1'b1 || stateOut !== 4'd0 || plot !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_erase: got over=%b srs=%b state=%0d plot=%b want 0 1 0 0",
               draw_over_car, set_reset_signals, stateOut, plot);
    end
    step();
    total++;
    if (draw_background !== 1'b1 || raceTime !== 16'd0) begin
      bad++;
      $display("FAIL reset_recover: got bg=%b time=%0d want 1 0", draw_background, raceTime);
    end
  endtask

  initial begin
    test_reset();
    test_go_start();
    test_move();
    test_crash();
    test_finish();
    test_reset_mid_erase();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/race_control.md
RACE_CONTROL -- requirements
Module: race_control

Interface
REQ-001 TICKS_PER_MOVE, default 833333, Clock cycles per movement tick (50 MHz / 60 Hz); legal range 2..2^20.
REQ-002 Clock  in  1  single system clock; all state changes on its rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 Go  in  1  level start/restart key, already synchronised to Clock.
REQ-005 KeyActive  in  1  OR of moveForward, moveRight and moveLeft.
REQ-006 DoneDrawBackground, DoneDrawCar, DoneDrawOverCar, DoneDrawExplosion  in  1 each  datapath completion flags.
REQ-007 FinishedRace, HitWall  in  1 each  datapath race status.
REQ-008 set_reset_signals, start_race, draw_background, draw_car, draw_over_car, move, draw_explosion  out  1 each  datapath commands.
REQ-009 plot  out  1  VGA write enable.
REQ-010 Crashed  out  1  sticky crash flag.
REQ-011 raceTime  out  16  elapsed race time in ticks.
REQ-012 stateOut  out  4  current state code, for debug.

Function
REQ-013 The controller SHALL be a Moore FSM; all command outputs are decoded combinationally from the state register only.
REQ-014 States and codes: S_RESET=0, S_DRAW_BG=1, S_WAIT_GO=2, S_WAIT_REL=3, S_START=4, S_DRAW_CAR=5, S_WAIT_TICK=6, S_ERASE=7, S_MOVE=8, S_EXPLODE=9, S_OVER=10. Codes 11-15 go to S_RESET.
REQ-015 S_RESET: assert set_reset_signals; go to S_DRAW_BG unconditionally (1 cycle).
REQ-016 S_DRAW_BG: assert draw_background; leave for S_WAIT_GO when DoneDrawBackground=1.
REQ-017 S_WAIT_GO: go to S_WAIT_REL when Go=1. S_WAIT_REL: go to S_START when Go=0.
REQ-018 S_START: assert start_race for 1 cycle; go to S_DRAW_CAR.
REQ-019 S_DRAW_CAR: assert draw_car. When DoneDrawCar=1, go to S_EXPLODE if HitWall=1, else S_WAIT_TICK. HitWall SHALL take priority when both rise in the same cycle.
REQ-020 S_WAIT_TICK, evaluated only on a tick cycle:
- FinishedRace=1 -> S_OVER.
- else KeyActive=1 -> S_ERASE.
- else remain.
- Non-tick cycles remain.
REQ-021 S_ERASE: assert draw_over_car; go to S_MOVE when DoneDrawOverCar=1.
REQ-022 S_MOVE: assert move for exactly 1 cycle; go to S_DRAW_CAR.
REQ-023 S_EXPLODE: assert draw_explosion; set Crashed=1; go to S_OVER when DoneDrawExplosion=1.
REQ-024 S_OVER: all commands low; Go rising edge (Go=1 while previous-cycle Go=0) -> S_RESET.
REQ-025 Tick counter: 20-bit, free-running 0..TICKS_PER_MOVE-1, wraps to 0. A tick cycle is one where count==TICKS_PER_MOVE-1.
REQ-026 raceTime: cleared in S_RESET; +1 on each tick while in states S_DRAW_CAR..S_MOVE; saturates at 0xFFFF; frozen in S_EXPLODE and S_OVER.
REQ-027 plot SHALL equal, delayed one cycle, (draw state active AND its Done flag=0), aligning with the datapath's registered xOut/yOut/colourOut. Draw states are S_DRAW_BG, S_DRAW_CAR, S_ERASE and S_EXPLODE.
REQ-028 At most one command output SHALL be high in any cycle.
REQ-029 Crashed clears only in S_RESET.

Reset
REQ-030 Reset=1 SHALL, on the next edge, from any state:
- state=S_RESET, tick count=0, raceTime=0, Crashed=0, plot=0, Go history=0.
- Hence set_reset_signals=1 in the first cycle after Reset.
REQ-031 Reset mid-draw SHALL abandon the draw; no command other than set_reset_signals is asserted in the following cycle.

Structure
REQ-032 State codes and TICKS_PER_MOVE default SHALL live in shared package race_pkg, which the datapath also imports.
REQ-033 The tick counter SHALL be sub-module tick_gen (parameter TICKS_PER_MOVE, output tick), instantiated once.

Verification (datapath modelled by a bench responder; TICKS_PER_MOVE=4)
REQ-034 Reset 2 cycles, then release:
- Cycle 1: set_reset_signals=1, stateOut=0.
- Cycle 2: draw_background=1.
- DoneDrawBackground pulse -> stateOut=2.
REQ-035 Hold Go for 3 cycles, then drop it -> exactly one start_race cycle follows the release, then draw_car=1.
REQ-036 DoneDrawCar=1 with HitWall=0 and KeyActive=1:
- Next tick -> draw_over_car=1.
- DoneDrawOverCar -> move=1 for 1 cycle -> draw_car=1.
- raceTime increments once per 4 cycles.
REQ-037 DoneDrawCar and HitWall both 1 in the same cycle:
- S_EXPLODE, Crashed=1.
- DoneDrawExplosion -> stateOut=10; raceTime frozen.
- Go edge -> set_reset_signals, Crashed=0.
REQ-038 FinishedRace=1 in S_WAIT_TICK -> S_OVER on the next tick, not before. Go held high through S_OVER SHALL NOT restart until low then high again.
REQ-039 Reset asserted while in S_ERASE -> draw_over_car=0 and set_reset_signals=1 on the next cycle. Also check: plot tracks draw_car one cycle late, and the one-hot command property holds throughout.
